// File: rtl/demux_pkg.sv
// Shared types for the registered 1-to-4 demux: lane count, lane index and lane state.
// No logic; imported by the lane holding register and the top level.
package demux_pkg;
    localparam int LANES = 4;

    typedef logic [1:0] lane_sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;
endpackage

// File: rtl/demux_lane.sv
// One destination lane: a holding register plus valid flag, loaded 1 cycle after fill.
// Backpressure: holds its word until drained; a same-cycle fill replaces the word with no bubble.
module demux_lane
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fill_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    lane_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (fill_i) begin
            state_d = FULL;
            data_d  = data_i;
        end else if (drain_i) begin
            // data is left in place after a drain; only the flag clears
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == FULL);
    assign data_o  = data_q;
endmodule

// File: rtl/one_four_demux_reg.sv
// Registered 1-to-4 demux: steers data_in to lane 'select', 1 cycle to out_valid; per-lane valid/ready.
// in_ready follows only the selected lane. Define DEMUX_CNT_EN to add the wrapping xfer_cnt accept counter.
module one_four_demux_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  lane_sel_t                   select,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            data_in,
    output logic [LANES-1:0]            out_valid,
    input  logic [LANES-1:0]            out_ready,
    output logic [LANES-1:0][WIDTH-1:0] data_out
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]                 xfer_cnt
`endif
);
    logic             accept;
    logic [LANES-1:0] fill;
    logic [LANES-1:0] drain;

    assign in_ready = !out_valid[select] || out_ready[select];
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid & out_ready;

    always_comb begin
        fill = '0;
        if (accept) begin
            fill[select] = 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        demux_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk_i  (Clk),
            .rst_i  (Reset),
            .fill_i (fill[i]),
            .drain_i(drain[i]),
            .data_i (data_in),
            .valid_o(out_valid[i]),
            .data_o (data_out[i])
        );
    end

`ifdef DEMUX_CNT_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    assign xfer_cnt_d = accept ? xfer_cnt_q + 16'd1 : xfer_cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif
endmodule

// File: tb/tb_one_four_demux_reg.sv
// Bench for one_four_demux_reg: vector table for in_ready/out_valid, per-lane queues for drained data.
// Build with DEMUX_CNT_EN defined to also exercise the counter wrap.
module tb_one_four_demux_reg;
    import demux_pkg::*;

    localparam int W = 16;

    logic                    Clk;
    logic                    Reset;
    lane_sel_t               select;
    logic                    in_valid;
    logic                    in_ready;
    logic [W-1:0]            data_in;
    logic [LANES-1:0]        out_valid;
    logic [LANES-1:0]        out_ready;
    logic [LANES-1:0][W-1:0] data_out;
`ifdef DEMUX_CNT_EN
    logic [15:0]             xfer_cnt;
`endif

    one_four_demux_reg #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .select   (select),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out)
`ifdef DEMUX_CNT_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: words are queued per lane on accept, popped and compared when the lane drains.
    logic [W-1:0] exp_q[LANES][$];

    always @(negedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LANES; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL drain_lane%0d: got %h expected no word (queue empty)", i, data_out[i]);
                    end else begin
                        check($sformatf("drain_lane%0d", i), {16'h0, data_out[i]}, {16'h0, exp_q[i].pop_front()});
                    end
                end
            end
            if (in_valid && in_ready) exp_q[select].push_back(data_in);
        end
    end

    typedef struct {
        lane_sel_t        sel;
        logic             vld;
        logic [W-1:0]     dat;
        logic [LANES-1:0] ordy;
        logic             exp_rdy;
        logic [LANES-1:0] exp_ov;  // out_valid observed during this row
    } vec_t;

    vec_t vecs[15];

    task automatic drive(input lane_sel_t s, input logic v, input logic [W-1:0] d, input logic [LANES-1:0] r);
        @(posedge Clk);
        #1;
        select    = s;
        in_valid  = v;
        data_in   = d;
        out_ready = r;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, {28'h0, out_valid}, 32'h0);
        for (int i = 0; i < LANES; i++)
            check($sformatf("%s_data_out%0d", tag, i), {16'h0, data_out[i]}, 32'h0);
`ifdef DEMUX_CNT_EN
        check({tag, "_xfer_cnt"}, {16'h0, xfer_cnt}, 32'h0);
`endif
    endtask

    initial begin
        //           sel vld  data      ordy     rdy  ov
        vecs[0]  = '{2'd2, 1'b1, 16'hBEEF, 4'b1111, 1'b1, 4'b0000};
        vecs[1]  = '{2'd0, 1'b0, 16'h0000, 4'b1111, 1'b1, 4'b0100};
        vecs[2]  = '{2'd1, 1'b1, 16'h1234, 4'b0000, 1'b1, 4'b0000};
        vecs[3]  = '{2'd1, 1'b1, 16'h5678, 4'b0000, 1'b0, 4'b0010};
        vecs[4]  = '{2'd1, 1'b1, 16'h5678, 4'b0010, 1'b1, 4'b0010};
        vecs[5]  = '{2'd3, 1'b1, 16'h0F0F, 4'b0000, 1'b1, 4'b0010};
        vecs[6]  = '{2'd0, 1'b1, 16'h00FF, 4'b0000, 1'b1, 4'b1010};
        vecs[7]  = '{2'd3, 1'b1, 16'hFFFF, 4'b0000, 1'b0, 4'b1011};
        vecs[8]  = '{2'd0, 1'b0, 16'h0000, 4'b0010, 1'b0, 4'b1011};
        vecs[9]  = '{2'd0, 1'b1, 16'hAAAA, 4'b0001, 1'b1, 4'b1001};
        vecs[10] = '{2'd2, 1'b1, 16'h2222, 4'b0000, 1'b1, 4'b1001};
        vecs[11] = '{2'd1, 1'b1, 16'h1111, 4'b0000, 1'b1, 4'b1101};
        vecs[12] = '{2'd2, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'b1111};
        vecs[13] = '{2'd0, 1'b0, 16'h0000, 4'b1111, 1'b1, 4'b1111};
        vecs[14] = '{2'd0, 1'b0, 16'h0000, 4'b0000, 1'b1, 4'b0000};

        Reset     = 1'b1;
        select    = '0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = '0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check_reset_state("reset");
        check("reset_in_ready", {31'h0, in_ready}, 32'h1);

        for (int k = 0; k < 15; k++) begin
            drive(vecs[k].sel, vecs[k].vld, vecs[k].dat, vecs[k].ordy);
            @(negedge Clk);
            check($sformatf("vec%0d_in_ready", k), {31'h0, in_ready}, {31'h0, vecs[k].exp_rdy});
            check($sformatf("vec%0d_out_valid", k), {28'h0, out_valid}, {28'h0, vecs[k].exp_ov});
        end

        // Lane 3 stalled holds its word while another lane is written
        drive(2'd3, 1'b1, 16'h0F0F, 4'b0000);
        drive(2'd0, 1'b1, 16'h00FF, 4'b0000);
        drive(2'd0, 1'b0, 16'h0000, 4'b0000);
        @(negedge Clk);
        check("stall_out_valid", {28'h0, out_valid}, 32'h9);
        check("stall_lane3", {16'h0, data_out[3]}, 32'h0F0F);
        check("stall_lane0", {16'h0, data_out[0]}, 32'h00FF);

        // Fill every lane, then reset with an offered word: reset must win
        for (int i = 0; i < LANES; i++)
            drive(lane_sel_t'(i), 1'b1, 16'hC000 | 16'(i), 4'b0000);
        drive(2'd0, 1'b0, 16'h0000, 4'b0000);
        @(negedge Clk);
        check("full_out_valid", {28'h0, out_valid}, 32'hF);
        @(posedge Clk);
        #1;
        Reset    = 1'b1;
        in_valid = 1'b1;
        data_in  = 16'h7777;
        out_ready = 4'b1111;
        @(posedge Clk);
        #1;
        Reset    = 1'b0;
        in_valid = 1'b0;
        out_ready = 4'b0000;
        @(negedge Clk);
        check_reset_state("midreset");

`ifdef DEMUX_CNT_EN
        for (int n = 0; n < 65535; n++)
            drive(2'd0, 1'b1, 16'(n), 4'b1111);
        drive(2'd0, 1'b0, 16'h0000, 4'b1111);
        @(negedge Clk);
        check("cnt_ffff", {16'h0, xfer_cnt}, 32'hFFFF);
        drive(2'd1, 1'b1, 16'h4242, 4'b1111);
        drive(2'd1, 1'b0, 16'h0000, 4'b1111);
        @(negedge Clk);
        check("cnt_wrap", {16'h0, xfer_cnt}, 32'h0000);
`endif

        repeat (2) @(posedge Clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
